// File: rtl/note_sequencer.sv
// note_sequencer: steps through a programmable note table, gating one of a bank of tone generators
// per step and muxing its sample into a registered stream. Define SEQ_GAP_EN for a silent tick between notes.
module note_sequencer #(
    parameter int num_notes_p = 4,
    parameter int steps_p     = 8,
    parameter int width_p     = 12,
    parameter int dur_width_p = 16
) (
    input  logic                               clk_i,
    input  logic                               reset_ni,
    input  logic                               sample_tick_i,
    input  logic                               start_i,
    input  logic                               stop_i,
    input  logic                               loop_i,
    input  logic [$clog2(steps_p+1)-1:0]       len_i,
    input  logic                               cfg_we_i,
    input  logic [$clog2(steps_p)-1:0]         cfg_addr_i,
    input  logic [$clog2(num_notes_p)-1:0]     cfg_note_i,
    input  logic                               cfg_rest_i,
    input  logic [dur_width_p-1:0]             cfg_dur_i,
    input  logic [num_notes_p*width_p-1:0]     data_i,
    output logic [$clog2(num_notes_p)-1:0]     note_sel_o,
    output logic                               gate_o,
    output logic                               osc_reset_o,
    output logic [$clog2(steps_p)-1:0]         step_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic signed [width_p-1:0]          data_o,
    output logic                               valid_o
);
    localparam int NoteW = $clog2(num_notes_p);
    localparam int StepW = $clog2(steps_p);
    localparam int LenW  = $clog2(steps_p + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_PLAY, ST_GAP} state_t;

    state_t                   r_state;
    logic [LenW-1:0]          r_len;
    logic [StepW-1:0]         r_step;
    logic [NoteW-1:0]         r_note;
    logic                     r_rest;
    logic [dur_width_p-1:0]   r_cnt;
    logic                     r_done;
    logic                     r_osc_rst;
    logic signed [width_p-1:0] r_data;
    logic                     r_valid;

    logic [NoteW-1:0]         r_tbl_note [steps_p];
    logic                     r_tbl_rest [steps_p];
    logic [dur_width_p-1:0]   r_tbl_dur  [steps_p];

    logic                     w_gate;
    logic                     w_last;
    logic                     w_decide;
    logic signed [width_p-1:0] w_sample;

    // NOTE: the pattern table is plain storage with no reset; its contents are undefined until written.
    always_ff @(posedge clk_i) begin
        if (cfg_we_i) begin
            r_tbl_note[cfg_addr_i] <= cfg_note_i;
            r_tbl_rest[cfg_addr_i] <= cfg_rest_i;
            r_tbl_dur[cfg_addr_i]  <= cfg_dur_i;
        end
    end

    assign w_gate = (r_state == ST_PLAY) && !r_rest;
    assign w_last = (LenW'(r_step) == r_len - 1'b1);

    // The end-of-step decision happens on the GAP tick, or directly on the final PLAY tick when legato.
`ifdef SEQ_GAP_EN
    assign w_decide = sample_tick_i && (r_state == ST_GAP);
`else
    assign w_decide = sample_tick_i && (r_state == ST_PLAY) && (r_cnt == dur_width_p'(1));
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values;
    // this is also why a FETCH coinciding with a write to the same address returns the old entry.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_step    <= '0;
            r_note    <= '0;
            r_rest    <= 1'b0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_osc_rst <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_osc_rst <= 1'b0;
            if (stop_i && (r_state != ST_IDLE)) begin
                r_state <= ST_IDLE;
            end else if (w_decide) begin
                if (w_last && !loop_i) begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end else begin
                    r_state   <= ST_FETCH;
                    r_osc_rst <= 1'b1;
                    r_step    <= w_last ? '0 : r_step + 1'b1;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start_i && !stop_i && (len_i != '0)) begin
                            r_len     <= len_i;
                            r_step    <= '0;
                            r_state   <= ST_FETCH;
                            r_osc_rst <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        r_note  <= r_tbl_note[r_step];
                        r_rest  <= r_tbl_rest[r_step];
                        r_cnt   <= (r_tbl_dur[r_step] == '0) ? dur_width_p'(1) : r_tbl_dur[r_step];
                        r_state <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        if (sample_tick_i) begin
                            r_cnt <= r_cnt - 1'b1;
`ifdef SEQ_GAP_EN
                            if (r_cnt == dur_width_p'(1)) r_state <= ST_GAP;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_sample = data_i[r_note*width_p +: width_p];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_data  <= w_gate ? w_sample : '0;
            r_valid <= sample_tick_i;
        end
    end

    assign note_sel_o  = r_note;
    assign gate_o      = w_gate;
    assign osc_reset_o = r_osc_rst;
    assign step_o      = r_step;
    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = r_done;
    assign data_o      = r_data;
    assign valid_o     = r_valid;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: scenario tasks push expected note events to a queue; a negedge monitor
// pops one per FETCH and scores step, note, gated ticks and total ticks, plus the sample path.
module tb_note_sequencer;
    localparam int NN = 4;
    localparam int NS = 8;
    localparam int W  = 12;
    localparam int DW = 16;
    localparam int TP = 4;
`ifdef SEQ_GAP_EN
    localparam int GAP_T = 1;
`else
    localparam int GAP_T = 0;
`endif

    logic               clk_i, reset_ni, sample_tick_i, start_i, stop_i, loop_i;
    logic [3:0]         len_i;
    logic               cfg_we_i;
    logic [2:0]         cfg_addr_i;
    logic [1:0]         cfg_note_i;
    logic               cfg_rest_i;
    logic [DW-1:0]      cfg_dur_i;
    logic [NN*W-1:0]    data_i;
    logic [1:0]         note_sel_o;
    logic               gate_o, osc_reset_o, busy_o, done_o, valid_o;
    logic [2:0]         step_o;
    logic signed [W-1:0] data_o;

    note_sequencer #(.num_notes_p(NN), .steps_p(NS), .width_p(W), .dur_width_p(DW)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .sample_tick_i(sample_tick_i),
        .start_i(start_i), .stop_i(stop_i), .loop_i(loop_i), .len_i(len_i),
        .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_note_i(cfg_note_i),
        .cfg_rest_i(cfg_rest_i), .cfg_dur_i(cfg_dur_i), .data_i(data_i),
        .note_sel_o(note_sel_o), .gate_o(gate_o), .osc_reset_o(osc_reset_o),
        .step_o(step_o), .busy_o(busy_o), .done_o(done_o), .data_o(data_o), .valid_o(valid_o)
    );

    typedef struct {
        int step;
        int note;
        int gate_ticks;
        int total_ticks;
    } ev_t;

    ev_t          exp_q[$];
    ev_t          cur_exp;
    int           checks, errors, done_cnt, fetch_cnt;
    bit           mon_en, have_cur, first_cyc, tick_en, dchk_ok;
    int           cur_step, cur_note, cur_ticks, cur_gate;
    logic [W-1:0] gen_val [NN];
    logic [W-1:0] exp_data;
    logic         exp_valid;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        int ph;
        ph = 0;
        sample_tick_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (tick_en) begin
                ph = (ph + 1) % TP;
                sample_tick_i = (ph == 0);
            end else begin
                sample_tick_i = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic mon_finish();
        checks++;
        if (cur_step != cur_exp.step) begin
            errors++;
            $display("FAIL ev_step got=%0d exp=%0d", cur_step, cur_exp.step);
        end
        checks++;
        if (cur_note != cur_exp.note) begin
            errors++;
            $display("FAIL ev_note step=%0d got=%0d exp=%0d", cur_exp.step, cur_note, cur_exp.note);
        end
        checks++;
        if (cur_gate != cur_exp.gate_ticks) begin
            errors++;
            $display("FAIL ev_gate_ticks step=%0d got=%0d exp=%0d", cur_exp.step, cur_gate, cur_exp.gate_ticks);
        end
        checks++;
        if (cur_ticks != cur_exp.total_ticks) begin
            errors++;
            $display("FAIL ev_total_ticks step=%0d got=%0d exp=%0d", cur_exp.step, cur_ticks, cur_exp.total_ticks);
        end
        have_cur = 1'b0;
    endtask

    // Note-event monitor: one scoreboard entry per FETCH, closed by the next FETCH or by going idle.
    always @(negedge clk_i) begin
        if (!mon_en || !reset_ni) begin
            have_cur = 1'b0;
        end else begin
            if (osc_reset_o) begin
                if (have_cur) mon_finish();
                fetch_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL fetch_unexpected step=%0d", step_o);
                end else begin
                    cur_exp   = exp_q.pop_front();
                    cur_step  = int'(step_o);
                    cur_ticks = 0;
                    cur_gate  = 0;
                    first_cyc = 1'b1;
                    have_cur  = 1'b1;
                end
            end else if (have_cur) begin
                if (first_cyc) begin
                    cur_note  = int'(note_sel_o);
                    first_cyc = 1'b0;
                end
                if (!busy_o) begin
                    mon_finish();
                end else if (sample_tick_i) begin
                    cur_ticks++;
                    if (gate_o) cur_gate++;
                end
            end
            if (done_o) done_cnt++;
        end
    end

    // Sample path: data_o and valid_o must follow gate/selection and the tick strobe one cycle later.
    always @(negedge clk_i) begin
        if (reset_ni && dchk_ok) begin
            checks++;
            if (data_o !== exp_data) begin
                errors++;
                $display("FAIL data_o got=%h exp=%h t=%0t", data_o, exp_data, $time);
            end
            checks++;
            if (valid_o !== exp_valid) begin
                errors++;
                $display("FAIL valid_o got=%b exp=%b t=%0t", valid_o, exp_valid, $time);
            end
        end
        exp_data  = gate_o ? gen_val[note_sel_o] : '0;
        exp_valid = sample_tick_i;
        dchk_ok   = reset_ni;
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input int a, input int n, input bit r, input int d);
        cfg_we_i   = 1'b1;
        cfg_addr_i = 3'(a);
        cfg_note_i = 2'(n);
        cfg_rest_i = r;
        cfg_dur_i  = DW'(d);
        cyc();
        cfg_we_i = 1'b0;
    endtask

    task automatic push(input int s, input int n, input bit r, input int d);
        ev_t e;
        int  eff;
        eff           = (d == 0) ? 1 : d;
        e.step        = s;
        e.note        = n;
        e.gate_ticks  = r ? 0 : eff;
        e.total_ticks = eff + GAP_T;
        exp_q.push_back(e);
    endtask

    task automatic start(input int l, input bit lp);
        start_i = 1'b1;
        len_i   = 4'(l);
        loop_i  = lp;
        cyc();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n;
        n = 0;
        while (busy_o && n < max_cyc) begin
            cyc();
            n++;
        end
        if (busy_o) begin
            checks++;
            errors++;
            $display("FAIL %s timeout busy_o still high after %0d cycles", name, max_cyc);
        end
        cyc();
    endtask

    task automatic check_end(input string name, input int d0, input int f0, input int exp_f);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL %s done_pulses got=%0d exp=1", name, done_cnt - d0);
        end
        checks++;
        if (fetch_cnt - f0 != exp_f) begin
            errors++;
            $display("FAIL %s fetches got=%0d exp=%0d", name, fetch_cnt - f0, exp_f);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s events_left got=%0d exp=0", name, exp_q.size());
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_o got=%b exp=0", name, busy_o);
        end
    endtask

    task automatic test_reset();
        reset_ni = 1'b1;
        #2 reset_ni = 1'b0;
        repeat (3) cyc();
        checks++;
        if ({note_sel_o, gate_o, osc_reset_o, step_o, busy_o, done_o, data_o, valid_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {note_sel_o, gate_o, osc_reset_o, step_o, busy_o, done_o, data_o, valid_o});
        end
        reset_ni = 1'b1;
        cyc();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy_o got=%b exp=0", busy_o);
        end
    endtask

    task automatic test_basic();
        int d0, f0;
        wr(0, 1, 1'b0, 2);
        wr(1, 0, 1'b1, 1);
        wr(2, 3, 1'b0, 3);
        push(0, 1, 1'b0, 2);
        push(1, 0, 1'b1, 1);
        push(2, 3, 1'b0, 3);
        d0 = done_cnt;
        f0 = fetch_cnt;
        start(3, 1'b0);
        wait_idle("basic", 300);
        check_end("basic", d0, f0, 3);
    endtask

    task automatic test_loop();
        int d0, f0, n;
        for (int p = 0; p < 2; p++) begin
            push(0, 1, 1'b0, 2);
            push(1, 0, 1'b1, 1);
            push(2, 3, 1'b0, 3);
        end
        d0 = done_cnt;
        f0 = fetch_cnt;
        start(3, 1'b1);
        n = 0;
        while (fetch_cnt - f0 < 6 && n < 400) begin
            cyc();
            n++;
        end
        checks++;
        if (fetch_cnt - f0 < 6) begin
            errors++;
            $display("FAIL loop_reach_second_pass fetches got=%0d exp=6", fetch_cnt - f0);
        end
        loop_i = 1'b0;
        wait_idle("loop", 300);
        check_end("loop", d0, f0, 6);
    endtask

    task automatic test_stop();
        int d0;
        mon_en = 1'b0;
        wr(0, 2, 1'b0, 5);
        d0 = done_cnt;
        start(1, 1'b0);
        checks++;
        if (osc_reset_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL stop_fetch osc_reset=%b busy=%b exp=1,1", osc_reset_o, busy_o);
        end
        cyc();
        checks++;
        if (gate_o !== 1'b1 || note_sel_o !== 2'd2 || osc_reset_o !== 1'b0) begin
            errors++;
            $display("FAIL stop_play gate=%b note=%0d osc=%b exp=1,2,0", gate_o, note_sel_o, osc_reset_o);
        end
        cyc();
        checks++;
        if (data_o !== 12'sh7FF) begin
            errors++;
            $display("FAIL stop_gen2_sample got=%h exp=7ff", data_o);
        end
        stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || gate_o !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle busy=%b gate=%b exp=0,0", busy_o, gate_o);
        end
        cyc();
        checks++;
        if (data_o !== '0) begin
            errors++;
            $display("FAIL stop_data_zero got=%h exp=0", data_o);
        end
        // start and stop together in IDLE: stop wins.
        start_i = 1'b1;
        stop_i  = 1'b1;
        len_i   = 4'd1;
        cyc();
        start_i = 1'b0;
        stop_i  = 1'b0;
        repeat (2) begin
            checks++;
            if (busy_o !== 1'b0 || osc_reset_o !== 1'b0) begin
                errors++;
                $display("FAIL start_stop_same busy=%b osc=%b exp=0,0", busy_o, osc_reset_o);
            end
            cyc();
        end
        repeat (4) cyc();
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL stop_no_done got=%0d exp=%0d", done_cnt, d0);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_dur0_len0();
        int d0, f0;
        wr(0, 3, 1'b0, 0);
        wr(1, 0, 1'b0, 1);
        push(0, 3, 1'b0, 0);
        push(1, 0, 1'b0, 1);
        d0 = done_cnt;
        f0 = fetch_cnt;
        start(2, 1'b0);
        wait_idle("dur0", 200);
        check_end("dur0", d0, f0, 2);
        f0 = fetch_cnt;
        start(0, 1'b0);
        repeat (3) begin
            checks++;
            if (busy_o !== 1'b0) begin
                errors++;
                $display("FAIL len0_ignored busy_o got=%b exp=0", busy_o);
            end
            cyc();
        end
        checks++;
        if (fetch_cnt != f0) begin
            errors++;
            $display("FAIL len0_no_fetch got=%0d exp=%0d", fetch_cnt - f0, 0);
        end
    endtask

    task automatic test_gap();
        int d0, f0, n, low;
        wr(0, 1, 1'b0, 1);
        wr(1, 1, 1'b0, 1);
        push(0, 1, 1'b0, 1);
        push(1, 1, 1'b0, 1);
        d0 = done_cnt;
        f0 = fetch_cnt;
        start(2, 1'b0);
        n = 0;
        while (!gate_o && n < 50) begin cyc(); n++; end
        while (gate_o && n < 100) begin cyc(); n++; end
        low = 0;
        while (!gate_o && low < 50) begin cyc(); low++; end
        checks++;
        if (low != ((GAP_T != 0) ? TP + 1 : 1)) begin
            errors++;
            $display("FAIL inter_note_gap got=%0d exp=%0d cycles", low, (GAP_T != 0) ? TP + 1 : 1);
        end
        wait_idle("gap", 200);
        check_end("gap", d0, f0, 2);
    endtask

    task automatic test_reset_mid();
        int d0, f0, n;
        mon_en = 1'b0;
        wr(0, 2, 1'b0, 4);
        wr(1, 1, 1'b0, 2);
        start(2, 1'b0);
        n = 0;
        while (!gate_o && n < 50) begin cyc(); n++; end
        cyc();
        #2 reset_ni = 1'b0;
        #1;
        checks++;
        if ({note_sel_o, gate_o, osc_reset_o, step_o, busy_o, done_o, data_o, valid_o} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs got=%h exp=0",
                     {note_sel_o, gate_o, osc_reset_o, step_o, busy_o, done_o, data_o, valid_o});
        end
        cyc();
        cyc();
        reset_ni = 1'b1;
        cyc();
        exp_q.delete();
        mon_en = 1'b1;
        wr(0, 2, 1'b0, 2);
        wr(1, 1, 1'b1, 1);
        push(0, 2, 1'b0, 2);
        push(1, 1, 1'b1, 1);
        d0 = done_cnt;
        f0 = fetch_cnt;
        start(2, 1'b0);
        wait_idle("replay", 200);
        check_end("replay", d0, f0, 2);
    endtask

    initial begin
        checks = 0; errors = 0; done_cnt = 0; fetch_cnt = 0;
        mon_en = 1'b1; have_cur = 1'b0; first_cyc = 1'b0; dchk_ok = 1'b0;
        exp_data = '0; exp_valid = 1'b0;
        start_i = 1'b0; stop_i = 1'b0; loop_i = 1'b0; len_i = '0;
        cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_note_i = '0; cfg_rest_i = 1'b0; cfg_dur_i = '0;
        gen_val[0] = 12'h055;
        gen_val[1] = 12'h123;
        gen_val[2] = 12'h7FF;
        gen_val[3] = 12'h800;
        data_i = {gen_val[3], gen_val[2], gen_val[1], gen_val[0]};
        tick_en = 1'b1;
        test_reset();
        test_basic();
        test_loop();
        test_stop();
        test_dur0_len0();
        test_gap();
        test_reset_mid();
        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
